// File: rtl/processor_pkg.sv
// Shared definitions for the processor sequencer: opcodes, instruction
// field positions, FSM state encoding and default widths.
package processor_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int INSTR_W    = 32;

  // Opcode values carried in the top nibble of the instruction word
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_LDI = 4'd4;

  // Instruction field bit positions; imm overlaps rs2 and is only meaningful for LDI
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int RD_HI  = 27;
  localparam int RD_LO  = 23;
  localparam int RS1_HI = 22;
  localparam int RS1_LO = 18;
  localparam int RS2_HI = 17;
  localparam int RS2_LO = 13;
  localparam int IMM_HI = 17;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = IMM_HI - IMM_LO + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  // Opcodes 5..15 are undefined
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_LDI);
  endfunction

endpackage

// File: rtl/processor_control_if.sv
// Bundle of the instruction handshake and the register-file port pair.
// The master side is the sequencer; the slave side is the instruction
// source together with the register file.
interface processor_control_if
  import processor_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;

  logic [ADDR_W-1:0]  rf_src1;
  logic [ADDR_W-1:0]  rf_src2;
  logic [DATA_W-1:0]  rf_data_out1;
  logic [DATA_W-1:0]  rf_data_out2;
  logic               rf_write;
  logic [ADDR_W-1:0]  rf_address;
  logic [DATA_W-1:0]  rf_data_in;

  modport master (
    input  instr_valid, instr, rf_data_out1, rf_data_out2,
    output instr_ready, rf_src1, rf_src2, rf_write, rf_address, rf_data_in
  );

  modport slave (
    output instr_valid, instr, rf_data_out1, rf_data_out2,
    input  instr_ready, rf_src1, rf_src2, rf_write, rf_address, rf_data_in
  );

endinterface

// File: rtl/processor_alu.sv
// Combinational execute unit: ADD/SUB/MUL/LDI result plus carry and zero.
// Undefined opcodes produce zero outputs; the sequencer never registers them.
module processor_alu
  import processor_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;

  // Select the result and carry for the current opcode
  always_comb begin
    sum    = {1'b0, op_a} + {1'b0, op_b};
    prod   = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = op_a - op_b;
        carry  = (op_a < op_b);
      end
      OP_MUL: begin
        result = prod[DATA_W-1:0];
        carry  = |prod[2*DATA_W-1:DATA_W];
      end
      OP_LDI: begin
        result = DATA_W'(imm);
        carry  = 1'b0;
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/processor_control.sv
// Multi-cycle instruction sequencer driving a register file:
// IDLE (accept) -> READ (operand capture) -> EXEC (ALU + flags) -> WB (write, done).
// NOP and undefined opcodes retire straight from IDLE without touching the register file.
module processor_control
  import processor_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  processor_control_if.master  bus,
  output logic                 done,
  output logic                 carry,
  output logic                 zero,
  output logic                 illegal
);

  state_e             state_q, state_d;
  logic [3:0]         opcode_q, opcode_d;
  logic [ADDR_W-1:0]  rd_q, rd_d;
  logic [IMM_W-1:0]   imm_q, imm_d;
  logic [ADDR_W-1:0]  src1_q, src1_d;
  logic [ADDR_W-1:0]  src2_q, src2_d;
  logic [DATA_W-1:0]  op_a_q, op_a_d;
  logic [DATA_W-1:0]  op_b_q, op_b_d;
  logic               rf_write_q, rf_write_d;
  logic [ADDR_W-1:0]  rf_address_q, rf_address_d;
  logic [DATA_W-1:0]  rf_data_in_q, rf_data_in_d;
  logic               done_q, done_d;
  logic               illegal_q, illegal_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;

  logic [3:0]         in_opcode;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_carry;
  logic               alu_zero;

  assign in_opcode = bus.instr[OPC_HI:OPC_LO];

  processor_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .opcode (opcode_q),
    .op_a   (op_a_q),
    .op_b   (op_b_q),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Next-state and registered-output logic for the four-phase sequence
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    rd_d         = rd_q;
    imm_d        = imm_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rf_write_d   = 1'b0;
    rf_address_d = rf_address_q;
    rf_data_in_d = rf_data_in_q;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    carry_d      = carry_q;
    zero_d       = zero_q;

    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          opcode_d = in_opcode;
          rd_d     = ADDR_W'(bus.instr[RD_HI:RD_LO]);
          imm_d    = bus.instr[IMM_HI:IMM_LO];
          src1_d   = ADDR_W'(bus.instr[RS1_HI:RS1_LO]);
          src2_d   = ADDR_W'(bus.instr[RS2_HI:RS2_LO]);
          if (in_opcode == OP_NOP) begin
            done_d = 1'b1;
          end else if (!is_legal_op(in_opcode)) begin
            done_d    = 1'b1;
            illegal_d = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        op_a_d  = bus.rf_data_out1;
        op_b_d  = bus.rf_data_out2;
        state_d = EXEC;
      end
      EXEC: begin
        rf_data_in_d = alu_result;
        carry_d      = alu_carry;
        zero_d       = alu_zero;
        rf_address_d = rd_q;
        rf_write_d   = 1'b1;
        done_d       = 1'b1;
        state_d      = WB;
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      opcode_q     <= '0;
      rd_q         <= '0;
      imm_q        <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rf_write_q   <= 1'b0;
      rf_address_q <= '0;
      rf_data_in_q <= '0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      rd_q         <= rd_d;
      imm_q        <= imm_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rf_write_q   <= rf_write_d;
      rf_address_q <= rf_address_d;
      rf_data_in_q <= rf_data_in_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
    end
  end

  // The write strobe is masked by reset so a reset landing on the WB cycle
  // stops the register file from committing the pending result on that edge.
  assign bus.rf_write    = rf_write_q & ~reset;
  assign bus.instr_ready = (state_q == IDLE);
  assign bus.rf_src1     = src1_q;
  assign bus.rf_src2     = src2_q;
  assign bus.rf_address  = rf_address_q;
  assign bus.rf_data_in  = rf_data_in_q;
  assign done            = done_q;
  assign illegal         = illegal_q;
  assign carry           = carry_q;
  assign zero            = zero_q;

endmodule

// File: tb/tb_processor_control.sv
// Directed bench for processor_control with a behavioural register file
// (combinational read, write on the rising edge).
module tb_processor_control;
  import processor_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic done;
  logic carry;
  logic zero;
  logic illegal;

  int checks = 0;
  int failures = 0;
  int writeCount = 0;
  int acceptCount = 0;

  logic [31:0] regs [32];

  always #5 clk = ~clk;

  processor_control_if bus ();

  processor_control dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .done    (done),
    .carry   (carry),
    .zero    (zero),
    .illegal (illegal)
  );

  assign bus.rf_data_out1 = regs[bus.rf_src1];
  assign bus.rf_data_out2 = regs[bus.rf_src2];

  // Behavioural register file write port plus write/accept counters
  always @(posedge clk) begin
    if (bus.rf_write) begin
      regs[bus.rf_address] <= bus.rf_data_in;
      writeCount++;
    end
    if (bus.instr_valid && bus.instr_ready && !reset) begin
      acceptCount++;
    end
  end

  function automatic logic [31:0] encR(input logic [3:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 13'd0};
  endfunction

  function automatic logic [31:0] encLdi(input logic [4:0] rd, input logic [17:0] imm);
    return {OP_LDI, rd, 5'd0, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one instruction and hold it until accepted; returns at the
  // falling edge of the cycle after the accept edge (the READ cycle).
  task automatic applyStimulus(input logic [31:0] ins);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("accept_ready", {63'd0, bus.instr_ready}, 64'd1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  task automatic runArith(input string tag, input logic [31:0] ins, input logic [4:0] rd,
                          input logic [31:0] data, input logic expC, input logic expZ);
    applyStimulus(ins);
    checkOutput({tag, "_busy"}, {63'd0, bus.instr_ready}, 64'd0);
    @(negedge clk);
    checkOutput({tag, "_exec_nowrite"}, {63'd0, bus.rf_write}, 64'd0);
    @(negedge clk);
    checkOutput({tag, "_write"}, {63'd0, bus.rf_write}, 64'd1);
    checkOutput({tag, "_addr"}, {59'd0, bus.rf_address}, {59'd0, rd});
    checkOutput({tag, "_data"}, {32'd0, bus.rf_data_in}, {32'd0, data});
    checkOutput({tag, "_done"}, {63'd0, done}, 64'd1);
    checkOutput({tag, "_carry"}, {63'd0, carry}, {63'd0, expC});
    checkOutput({tag, "_zero"}, {63'd0, zero}, {63'd0, expZ});
    @(negedge clk);
    checkOutput({tag, "_ready_again"}, {63'd0, bus.instr_ready}, 64'd1);
    checkOutput({tag, "_write_off"}, {63'd0, bus.rf_write}, 64'd0);
    checkOutput({tag, "_done_off"}, {63'd0, done}, 64'd0);
    checkOutput({tag, "_reg"}, {32'd0, regs[rd]}, {32'd0, data});
  endtask

  task automatic runNoWrite(input string tag, input logic [31:0] ins, input logic expIll,
                            input logic expC, input logic expZ);
    int w0;
    w0 = writeCount;
    applyStimulus(ins);
    checkOutput({tag, "_done"}, {63'd0, done}, 64'd1);
    checkOutput({tag, "_illegal"}, {63'd0, illegal}, {63'd0, expIll});
    checkOutput({tag, "_carry_kept"}, {63'd0, carry}, {63'd0, expC});
    checkOutput({tag, "_zero_kept"}, {63'd0, zero}, {63'd0, expZ});
    checkOutput({tag, "_ready"}, {63'd0, bus.instr_ready}, 64'd1);
    @(negedge clk);
    checkOutput({tag, "_done_off"}, {63'd0, done}, 64'd0);
    checkOutput({tag, "_illegal_off"}, {63'd0, illegal}, 64'd0);
    repeat (2) @(negedge clk);
    checkOutput({tag, "_no_write"}, 64'(writeCount - w0), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0;
    int a0;
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    checkOutput("rst_ready", {63'd0, bus.instr_ready}, 64'd1);
    checkOutput("rst_write", {63'd0, bus.rf_write}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_illegal", {63'd0, illegal}, 64'd0);
    checkOutput("rst_carry", {63'd0, carry}, 64'd0);
    checkOutput("rst_zero", {63'd0, zero}, 64'd0);
    checkOutput("rst_src1", {59'd0, bus.rf_src1}, 64'd0);
    checkOutput("rst_src2", {59'd0, bus.rf_src2}, 64'd0);
    checkOutput("rst_addr", {59'd0, bus.rf_address}, 64'd0);
    checkOutput("rst_data", {32'd0, bus.rf_data_in}, 64'd0);

    $display("[TB] LDI and ADD");
    runArith("ldi_r1_5", 32'h4080_0005, 5'd1, 32'd5, 1'b0, 1'b0);
    runArith("ldi_r1_ffff", encLdi(5'd1, 18'h0FFFF), 5'd1, 32'h0000_FFFF, 1'b0, 1'b0);
    runArith("ldi_r2_1", encLdi(5'd2, 18'd1), 5'd2, 32'd1, 1'b0, 1'b0);
    runArith("add_r3", encR(OP_ADD, 5'd3, 5'd1, 5'd2), 5'd3, 32'h0001_0000, 1'b0, 1'b0);

    $display("[TB] SUB borrow and ADD wrap");
    runArith("ldi_r1_2", encLdi(5'd1, 18'd2), 5'd1, 32'd2, 1'b0, 1'b0);
    runArith("sub_r0", encR(OP_SUB, 5'd0, 5'd2, 5'd1), 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    runArith("add_wrap", encR(OP_ADD, 5'd7, 5'd0, 5'd2), 5'd7, 32'd0, 1'b1, 1'b1);

    $display("[TB] MUL");
    runArith("ldi_r1_10000", encLdi(5'd1, 18'h10000), 5'd1, 32'h0001_0000, 1'b0, 1'b0);
    runArith("mul_ovf", encR(OP_MUL, 5'd3, 5'd1, 5'd1), 5'd3, 32'd0, 1'b1, 1'b1);
    runArith("ldi_r8_3", encLdi(5'd8, 18'd3), 5'd8, 32'd3, 1'b0, 1'b0);
    runArith("ldi_r9_7", encLdi(5'd9, 18'd7), 5'd9, 32'd7, 1'b0, 1'b0);
    runArith("mul_21", encR(OP_MUL, 5'd10, 5'd8, 5'd9), 5'd10, 32'd21, 1'b0, 1'b0);

    $display("[TB] rd equals rs");
    runArith("ldi_r4_5", encLdi(5'd4, 18'd5), 5'd4, 32'd5, 1'b0, 1'b0);
    runArith("add_r4_self", encR(OP_ADD, 5'd4, 5'd4, 5'd4), 5'd4, 32'd10, 1'b0, 1'b0);

    $display("[TB] illegal and NOP keep flags");
    runArith("mul_set_flags", encR(OP_MUL, 5'd3, 5'd1, 5'd1), 5'd3, 32'd0, 1'b1, 1'b1);
    runNoWrite("illegal_f", 32'hF000_0000, 1'b1, 1'b1, 1'b1);
    runNoWrite("nop", 32'h0000_0000, 1'b0, 1'b1, 1'b1);

    $display("[TB] reset during EXEC");
    runArith("ldi_r11", encLdi(5'd11, 18'd10), 5'd11, 32'd10, 1'b0, 1'b0);
    runArith("ldi_r12", encLdi(5'd12, 18'd20), 5'd12, 32'd20, 1'b0, 1'b0);
    runArith("ldi_r13", encLdi(5'd13, 18'd99), 5'd13, 32'd99, 1'b0, 1'b0);
    w0 = writeCount;
    applyStimulus(encR(OP_ADD, 5'd13, 5'd11, 5'd12));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rexec_write", {63'd0, bus.rf_write}, 64'd0);
    checkOutput("rexec_done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rexec_ready", {63'd0, bus.instr_ready}, 64'd1);
    repeat (4) @(negedge clk);
    checkOutput("rexec_no_write", 64'(writeCount - w0), 64'd0);
    checkOutput("rexec_r13", {32'd0, regs[13]}, 64'd99);

    $display("[TB] reset during WB");
    w0 = writeCount;
    applyStimulus(encR(OP_ADD, 5'd13, 5'd11, 5'd12));
    @(negedge clk);
    @(negedge clk);
    checkOutput("rwb_pending", {63'd0, bus.rf_write}, 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("rwb_masked", {63'd0, bus.rf_write}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rwb_ready", {63'd0, bus.instr_ready}, 64'd1);
    checkOutput("rwb_done", {63'd0, done}, 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("rwb_no_write", 64'(writeCount - w0), 64'd0);
    checkOutput("rwb_r13", {32'd0, regs[13]}, 64'd99);

    $display("[TB] valid held for 6 cycles");
    a0 = acceptCount;
    w0 = writeCount;
    @(negedge clk);
    bus.instr       = encLdi(5'd14, 18'h123);
    bus.instr_valid = 1'b1;
    repeat (6) @(negedge clk);
    bus.instr_valid = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("hold_accepts", 64'(acceptCount - a0), 64'd2);
    checkOutput("hold_writes", 64'(writeCount - w0), 64'd2);
    checkOutput("hold_r14", {32'd0, regs[14]}, 64'h123);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
